// File: rtl/io_bus_pkg.sv
// Shared types and constants for the memory-mapped I/O controller.
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } io_state_t;

  localparam logic [1:0] LED_OFS  = 2'd0;
  localparam logic [1:0] SEG_OFS  = 2'd1;
  localparam logic [1:0] STAT_OFS = 2'd2;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/io_ch_decode.sv
// Priority decode of the word address into external channel / local register hits.
module io_ch_decode
  import io_bus_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned CH_BASE_BIT = 20,
  parameter int unsigned LOCAL_BIT   = 19,
  parameter int unsigned CH_IW       = 3
) (
  input  logic [29:0]      i_word,
  output logic             o_hit_ext,
  output logic [CH_IW-1:0] o_ch_idx,
  output logic             o_hit_local
);

  logic w_unused;
  assign w_unused = ^i_word;

  // Ascending scan: the last set bit seen is the highest index, which wins.
  always_comb begin
    o_hit_ext = 1'b0;
    o_ch_idx  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (i_word[CH_BASE_BIT + i]) begin
        o_hit_ext = 1'b1;
        o_ch_idx  = CH_IW'(i);
      end
    end
    o_hit_local = i_word[LOCAL_BIT] & ~o_hit_ext;
  end

endmodule

// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O controller: channel request/ack handshake, local LED/segment/status registers.
// Optional peripheral timeout recovery is compiled in with `define IO_TIMEOUT_EN.
module io_bus_ctrl
  import io_bus_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned CH_BASE_BIT = 20,
  parameter int unsigned LOCAL_BIT   = 19,
  parameter int unsigned LED_W       = 5,
  parameter int unsigned SEG_W       = 16,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_en,
  input  logic                 cpu_store,
  input  logic                 cpu_load,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic [31:0]          mem_rdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_stall,
  output logic [NUM_CH-1:0]    ch_req,
  output logic                 ch_we,
  output logic [21:0]          ch_addr,
  output logic [31:0]          ch_wdata,
  input  logic [NUM_CH*32-1:0] ch_rdata,
  input  logic [NUM_CH-1:0]    ch_ack,
  output logic [LED_W-1:0]     leds,
  output logic [SEG_W-1:0]     segments,
  output logic                 err,
  output logic [31:0]          err_addr
);

  localparam int unsigned CH_IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef IO_TIMEOUT_EN
  localparam int unsigned AW = 32;
`else
  localparam int unsigned AW = 22;
`endif

  io_state_t        r_state, w_next;
  logic [CH_IW-1:0] r_ch;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic [LED_W-1:0] r_leds;
  logic [SEG_W-1:0] r_seg;

  logic             w_hit_ext, w_hit_local;
  logic [CH_IW-1:0] w_ch_idx;
  logic             w_acc, w_ext, w_loc;
  logic [1:0]       w_off;
  logic             w_ack, w_tmo, w_err;
  logic [31:0]      w_ch_rdata, w_loc_rdata, w_err_addr;
  logic             w_unused;

  io_ch_decode #(
    .NUM_CH      (NUM_CH),
    .CH_BASE_BIT (CH_BASE_BIT),
    .LOCAL_BIT   (LOCAL_BIT),
    .CH_IW       (CH_IW)
  ) u_decode (
    .i_word      (cpu_addr[31:2]),
    .o_hit_ext   (w_hit_ext),
    .o_ch_idx    (w_ch_idx),
    .o_hit_local (w_hit_local)
  );

  assign w_unused   = ^cpu_addr[1:0];
  assign w_acc      = cpu_en & (cpu_store | cpu_load);
  assign w_ext      = w_acc & w_hit_ext;
  assign w_loc      = w_acc & w_hit_local;
  assign w_off      = cpu_addr[3:2];
  assign w_ack      = ch_ack[r_ch];
  assign w_ch_rdata = ch_rdata[32*r_ch +: 32];

`ifdef IO_TIMEOUT_EN
  logic [7:0]  r_cnt;
  logic        r_err;
  logic [31:0] r_err_addr;

  // Abort on the WAIT cycle that brings the counter up to TIMEOUT.
  assign w_tmo      = (r_cnt == 8'(TIMEOUT - 1));
  assign w_err      = r_err;
  assign w_err_addr = r_err_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      if (r_state == IDLE && w_ext) begin
        r_cnt <= '0;
      end else if (r_state == WAIT && !w_ack) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_tmo) begin
          r_err <= 1'b1;
          if (!r_err) r_err_addr <= r_addr;
        end
      end
      if (w_loc && cpu_store && w_off == STAT_OFS && cpu_wdata[0]) begin
        r_err      <= 1'b0;
        r_err_addr <= '0;
      end
    end
  end
`else
  assign w_tmo      = 1'b0;
  assign w_err      = 1'b0;
  assign w_err_addr = '0;
`endif

  always_comb begin
    w_loc_rdata = '0;
    case (w_off)
      LED_OFS:  w_loc_rdata = 32'(r_leds);
      SEG_OFS:  w_loc_rdata = 32'(r_seg);
      STAT_OFS: w_loc_rdata = 32'(w_err);
      default:  w_loc_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cpu_stall = 1'b0;
    ch_req    = '0;
    cpu_rdata = mem_rdata;
    case (r_state)
      IDLE: begin
        cpu_stall = w_ext;
        if (w_ext) w_next = WAIT;
        if (w_loc) cpu_rdata = w_loc_rdata;
      end
      WAIT: begin
        cpu_stall = 1'b1;
        ch_req    = NUM_CH'(1) << r_ch;
        if (w_ack || w_tmo) w_next = DONE;
      end
      DONE: begin
        if (!r_we) cpu_rdata = r_rdata;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ch    <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_leds  <= '0;
      r_seg   <= '0;
    end else begin
      if (r_state == IDLE && w_ext) begin
        r_ch    <= w_ch_idx;
        r_we    <= cpu_store;
        r_addr  <= cpu_addr[AW-1:0];
        r_wdata <= cpu_wdata;
      end
      if (r_state == WAIT) begin
        if (w_ack)      r_rdata <= w_ch_rdata;
        else if (w_tmo) r_rdata <= TIMEOUT_RDATA;
      end
      if (w_loc && cpu_store) begin
        case (w_off)
          LED_OFS: r_leds <= cpu_wdata[LED_W-1:0];
          SEG_OFS: r_seg  <= cpu_wdata[SEG_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign ch_we    = r_we;
  assign ch_addr  = r_addr[21:0];
  assign ch_wdata = r_wdata;
  assign leds     = r_leds;
  assign segments = r_seg;
  assign err      = w_err;
  assign err_addr = w_err_addr;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Self-checking bench for io_bus_ctrl: local register table, channel handshakes, reset and
// (with IO_TIMEOUT_EN) timeout recovery, plus randomized traffic against a behavioural model.
module tb_io_bus_ctrl;

  localparam int CHB = 22;             // byte-address bit of channel 0
  localparam logic [31:0] LOC = 32'h0020_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_en, cpu_store, cpu_load;
  logic [31:0]  cpu_addr, cpu_wdata, mem_rdata, cpu_rdata;
  logic         cpu_stall;
  logic [7:0]   ch_req, ch_ack;
  logic         ch_we;
  logic [21:0]  ch_addr;
  logic [31:0]  ch_wdata;
  logic [255:0] ch_rdata;
  logic [4:0]   leds;
  logic [15:0]  segments;
  logic         err;
  logic [31:0]  err_addr;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0]  leds_m;
  logic [15:0] seg_m;
  logic        err_m;
  logic [31:0] erra_m;

  io_bus_ctrl #(
    .NUM_CH(8), .CH_BASE_BIT(20), .LOCAL_BIT(19), .LED_W(5), .SEG_W(16), .TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .cpu_store(cpu_store), .cpu_load(cpu_load),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .mem_rdata(mem_rdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_ack(ch_ack), .leds(leds),
    .segments(segments), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int hi_ch(input logic [31:0] a);
    for (int i = 7; i >= 0; i--)
      if (a[CHB + i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] loc_exp(input logic [1:0] off);
    case (off)
      2'd0:    return 32'(leds_m);
      2'd1:    return 32'(seg_m);
      2'd2:    return 32'(err_m);
      default: return 32'h0;
    endcase
  endfunction

  // One external access. delay = WAIT cycle (1-based) in which the ack is given; 0 = never.
  task automatic ext_access(input logic [31:0] addr, input logic st, input logic [31:0] wd,
                            input logic [31:0] rd, input int delay, input bit noise);
    int          ec;
    int          stall_n;
    int          wait_n;
    bit          done;
    bit          bad_req;
    logic [31:0] mrd;
    logic [31:0] exp_rd;
    int          exp_stall;
    ec = hi_ch(addr);
    stall_n = 0; wait_n = 0; done = 0; bad_req = 0;
    mrd = $urandom;
    exp_stall = (delay == 0) ? 256 : 1 + delay;
    exp_rd = st ? mrd : ((delay == 0) ? 32'hDEAD_BEEF : rd);
    for (int i = 0; i < 8; i++) ch_rdata[32*i +: 32] = $urandom;
    ch_rdata[32*ec +: 32] = ~rd;
    cpu_en = 1; cpu_store = st; cpu_load = !st; cpu_addr = addr; cpu_wdata = wd; mem_rdata = mrd;
    #1;
    chk("ext_accept_stall", cpu_stall, 1);
    chk("ext_accept_noreq", ch_req, 0);
    for (int k = 0; k < 400 && !done; k++) begin
      if (!cpu_stall) done = 1;
      else begin
        stall_n++;
        if (ch_req != 0) begin
          wait_n++;
          if (ch_req !== 8'(8'd1 << ec)) bad_req = 1;
          if (wait_n == 1) begin
            chk("ext_ch_addr", 32'(ch_addr), 32'(addr[21:0]));
            chk("ext_ch_we", ch_we, st);
            if (st) chk("ext_ch_wdata", ch_wdata, wd);
          end
          if (wait_n == delay) begin
            ch_ack = 8'd1 << ec;
            ch_rdata[32*ec +: 32] = rd;
          end else begin
            ch_ack = noise ? ~(8'd1 << ec) : 8'h00;
          end
        end
        tick();
        ch_ack = '0;
        ch_rdata[32*ec +: 32] = ~rd;
      end
    end
    chk("ext_completed", done, 1);
    chk("ext_stall_cycles", stall_n, exp_stall);
    chk("ext_req_onehot", bad_req, 0);
    chk("ext_done_noreq", ch_req, 0);
    chk("ext_done_rdata", cpu_rdata, exp_rd);
    cpu_en = 0;
    tick();
    chk("ext_after_noreq", ch_req, 0);
  endtask

  typedef struct {
    logic        en, st, ld;
    logic [31:0] addr, wdata, mrd;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic [4:0]  exp_led;
    logic [15:0] exp_seg;
  } vec_t;

  vec_t        tbl[13];
  logic [31:0] a, wd, base;
  logic [7:0]  chb;
  logic [1:0]  off;
  logic        st;
  int unsigned kind;

  initial begin
    tbl[0]  = '{1, 1, 0, LOC,            32'h0000_001F, 32'h1111_1111, 0, 32'h0,          5'h1F, 16'h0000};
    tbl[1]  = '{1, 0, 1, LOC,            32'h0,         32'hAAAA_AAAA, 1, 32'h0000_001F,  5'h1F, 16'h0000};
    tbl[2]  = '{1, 1, 0, LOC | 32'h4,    32'h1234_BEEF, 32'h0,         0, 32'h0,          5'h1F, 16'hBEEF};
    tbl[3]  = '{1, 0, 1, LOC | 32'h4,    32'h0,         32'h5555_5555, 1, 32'h0000_BEEF,  5'h1F, 16'hBEEF};
    tbl[4]  = '{1, 0, 1, LOC | 32'h8,    32'h0,         32'h7777_7777, 1, 32'h0,          5'h1F, 16'hBEEF};
    tbl[5]  = '{1, 1, 0, LOC | 32'hC,    32'hFFFF_FFFF, 32'h0,         0, 32'h0,          5'h1F, 16'hBEEF};
    tbl[6]  = '{1, 0, 1, LOC | 32'hC,    32'h0,         32'h8888_8888, 1, 32'h0,          5'h1F, 16'hBEEF};
    tbl[7]  = '{0, 1, 1, LOC,            32'h0,         32'h1357_9BDF, 1, 32'h1357_9BDF,  5'h1F, 16'hBEEF};
    tbl[8]  = '{1, 0, 1, 32'h0000_1000,  32'h0,         32'hCAFE_F00D, 1, 32'hCAFE_F00D,  5'h1F, 16'hBEEF};
    tbl[9]  = '{1, 1, 0, 32'h0000_0000,  32'h0,         32'h0,         0, 32'h0,          5'h1F, 16'hBEEF};
    tbl[10] = '{1, 0, 0, 32'h0200_0000,  32'h0,         32'h2468_ACE0, 1, 32'h2468_ACE0,  5'h1F, 16'hBEEF};
    tbl[11] = '{1, 1, 0, LOC | 32'h3,    32'hFFFF_FFE3, 32'h0,         0, 32'h0,          5'h03, 16'hBEEF};
    tbl[12] = '{1, 0, 1, 32'hC020_0005,  32'h0,         32'h0,         1, 32'h0000_BEEF,  5'h03, 16'hBEEF};

    reset = 1; cpu_en = 0; cpu_store = 0; cpu_load = 0; cpu_addr = 0; cpu_wdata = 0;
    mem_rdata = 0; ch_ack = 0; ch_rdata = '0;
    tick(); tick();
    chk("rst_ch_req", ch_req, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_ch_we", ch_we, 0);
    chk("rst_ch_addr", 32'(ch_addr), 0);
    chk("rst_ch_wdata", ch_wdata, 0);
    chk("rst_leds", 32'(leds), 0);
    chk("rst_segments", 32'(segments), 0);
    chk("rst_err", err, 0);
    chk("rst_err_addr", err_addr, 0);
    reset = 0;
    tick();

    for (int i = 0; i < 13; i++) begin
      cpu_en = tbl[i].en; cpu_store = tbl[i].st; cpu_load = tbl[i].ld;
      cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wdata; mem_rdata = tbl[i].mrd;
      #1;
      chk($sformatf("tbl%0d_stall", i), cpu_stall, 0);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), cpu_rdata, tbl[i].exp_rd);
      tick();
      chk($sformatf("tbl%0d_leds", i), 32'(leds), 32'(tbl[i].exp_led));
      chk($sformatf("tbl%0d_seg", i), 32'(segments), 32'(tbl[i].exp_seg));
    end
    cpu_en = 0;
    leds_m = 5'h03; seg_m = 16'hBEEF; err_m = 0; erra_m = 0;
    tick();

    ext_access(32'h0200_0040, 0, 32'h0, 32'h1234_5678, 4, 0);   // channel 3 load
    ext_access(32'h0900_0010, 1, 32'hA5A5_0F0F, 32'h0, 3, 1);   // channels 2+5, noise acks
    ext_access(32'h0040_0000, 0, 32'h0, 32'h0BAD_F00D, 1, 0);   // ack in first WAIT cycle

    // Reset in the second WAIT cycle, with an ack pending.
    cpu_en = 1; cpu_store = 1; cpu_load = 0; cpu_addr = LOC; cpu_wdata = 32'h0A;
    tick();
    cpu_store = 0; cpu_load = 1; cpu_addr = 32'h0080_0040;
    tick();
    tick();
    chk("rst_mid_req_before", ch_req, 8'h02);
    reset = 1; ch_ack = 8'h02; cpu_en = 0;
    tick();
    chk("rst_mid_req", ch_req, 0);
    chk("rst_mid_stall", cpu_stall, 0);
    chk("rst_mid_leds", 32'(leds), 0);
    reset = 0; ch_ack = 8'h02;
    tick();
    ch_ack = 0;
    chk("rst_mid_ack_discarded", ch_req, 0);
    leds_m = 0; seg_m = 0; err_m = 0; erra_m = 0;
    ext_access(32'h0080_0100, 0, 32'h0, 32'h7654_3210, 2, 0);

`ifdef IO_TIMEOUT_EN
    ext_access(32'h1000_1234, 0, 32'h0, 32'h1111_2222, 0, 0);
    chk("tmo_err", err, 1);
    chk("tmo_err_addr", err_addr, 32'h1000_1234);
    ext_access(32'h0400_0008, 0, 32'h0, 32'h3333_4444, 255, 0);  // ack ties with timeout
    ext_access(32'h0100_0020, 1, 32'h9, 32'h0, 0, 0);
    chk("tmo_err_addr_sticky", err_addr, 32'h1000_1234);
    cpu_en = 1; cpu_store = 0; cpu_load = 1; cpu_addr = LOC | 32'h8;
    #1;
    chk("tmo_status_read", cpu_rdata, 1);
    cpu_store = 1; cpu_load = 0; cpu_wdata = 32'h1;
    tick();
    cpu_en = 0;
    chk("tmo_clear_err", err, 0);
    chk("tmo_clear_addr", err_addr, 0);
`endif

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      base = $urandom & 32'hC01F_FFFF;
      st = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (kind == 0) begin
        chb = 8'($urandom_range(1, 255));
        a = base | (32'(chb) << CHB) | (32'($urandom_range(0, 1)) << 21);
        ext_access(a, st, wd, $urandom, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
      end else begin
        off = 2'($urandom_range(0, 3));
        a = (kind == 1) ? ((base & 32'hFFFF_FFF3) | LOC | (32'(off) << 2)) : base;
        cpu_en = 1; cpu_store = st; cpu_load = !st; cpu_addr = a; cpu_wdata = wd;
        mem_rdata = $urandom;
        #1;
        chk("rnd_stall", cpu_stall, 0);
        if (!st) chk("rnd_rdata", cpu_rdata, (kind == 1) ? loc_exp(off) : mem_rdata);
        tick();
        if (st && kind == 1) begin
          if (off == 0) leds_m = wd[4:0];
          if (off == 1) seg_m = wd[15:0];
          if (off == 2 && wd[0]) begin err_m = 0; erra_m = 0; end
        end
        chk("rnd_leds", 32'(leds), 32'(leds_m));
        chk("rnd_seg", 32'(segments), 32'(seg_m));
        chk("rnd_err", err, err_m);
        cpu_en = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/io_bus_ctrl.md
# io_bus_ctrl

Parametrised memory-mapped I/O controller between the single-cycle RISC-V core's data port and its peripherals. It decodes one-hot channel address bits into up to NUM_CH external channels with a request/acknowledge handshake, and stalls the core until the addressed peripheral answers. It also owns local LED, segment and status registers. With the timeout feature compiled in, it recovers from unresponsive peripherals and records the failing address.

## Interface
Parameters:
- NUM_CH, 8: number of external channels (1..8).
- CH_BASE_BIT, 20: word-address bit selecting channel 0; channel i uses bit CH_BASE_BIT+i. Legal only if CH_BASE_BIT+NUM_CH <= 30.
- LOCAL_BIT, 19: word-address bit selecting local registers. Must be < CH_BASE_BIT.
- LED_W, 5: LED register width.
- SEG_W, 16: segment register width.
- TIMEOUT, 255: maximum WAIT cycles before abort (8-bit counter).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cpu_en  in  1  data access valid.
- cpu_store  in  1  store.
- cpu_load  in  1  load.
- cpu_addr  in  32  byte address; word address = cpu_addr[31:2].
- cpu_wdata  in  32  store data.
- mem_rdata  in  32  RAM read data (passthrough).
- cpu_rdata  out  32  read data returned to the core.
- cpu_stall  out  1  holds the core's PC and access stable.
- ch_req  out  NUM_CH  one-hot channel request.
- ch_we  out  1  1 = write.
- ch_addr  out  22  cpu_addr[21:0], registered at acceptance.
- ch_wdata  out  32  registered store data.
- ch_rdata  in  NUM_CH*32  channel i occupies bits [32i+31:32i].
- ch_ack  in  NUM_CH  per-channel acknowledge.
- leds  out  LED_W  LED register.
- segments  out  SEG_W  segment register.
- err  out  1  sticky timeout flag.
- err_addr  out  32  address of the first timed-out access.

## Operation
- Decode. An IO access is cpu_en & (cpu_store | cpu_load) with any channel bit or LOCAL_BIT set.
  - If several channel bits are set, the highest index wins.
  - LOCAL_BIT is honoured only when no channel bit is set.
  - Accesses with none of these bits set are not IO: cpu_rdata = mem_rdata and the block never stalls.
- Local registers, selected by cpu_addr[3:2]:
  - 0: LEDs.
  - 1: segments.
  - 2: status, bit0 = err. Writing 1 to bit0 clears err and err_addr.
  - 3: reads 0; writes are ignored.
  - Writes take effect at the clock edge, using the low bits of cpu_wdata. Reads are combinational. Local accesses never stall.
- FSM states IDLE, WAIT, DONE:
  - IDLE: an external channel access raises cpu_stall combinationally. At the edge, the block latches channel, ch_we = cpu_store, ch_addr and ch_wdata, clears the counter, and moves to WAIT.
  - WAIT: ch_req[ch] = 1 and cpu_stall = 1. When ch_ack[ch] is seen, the block latches ch_rdata[ch] into rdata_q and moves to DONE. Acks on other channels are ignored.
  - DONE: ch_req = 0, cpu_stall = 0, and cpu_rdata = rdata_q for loads (mem_rdata for stores). The core retires the access this cycle. Next state is IDLE unconditionally, so the retired access is never re-triggered.

## Timing
- Reset values: FSM in IDLE; ch_req, ch_we, ch_addr, ch_wdata, rdata_q, leds, segments, err, err_addr and the counter all 0.
- Reset mid-transaction: ch_req drops at that same edge and the pending ack is discarded.
- External access latency: acceptance edge, then WAIT for at least 1 cycle (an ack in the first WAIT cycle is legal), then 1 DONE cycle. Minimum stall is 2 cycles; data appears 3 cycles after the access starts.
- ch_req stays high continuously from entering WAIT until the ack edge. Peripherals must drop ack within 1 cycle after ch_req falls.
- A local write in the same cycle as an external transaction is impossible, because the core is stalled.

## Configuration
- IO_TIMEOUT_EN defined:
  - The counter increments in every WAIT cycle without an ack.
  - When the counter equals TIMEOUT, the block moves to DONE with rdata_q = 32'hDEAD_BEEF.
  - err is set; err_addr captures the latched address only if err was clear.
  - An ack arriving in the same cycle as the timeout wins.
- IO_TIMEOUT_EN undefined: WAIT lasts until the ack, with no upper bound. The counter is absent, err and err_addr are tied to 0, and status reads 0.

## Structure
- Package io_bus_pkg holds:
  - enum io_state_t {IDLE, WAIT, DONE}.
  - Local offset constants LED_OFS = 0, SEG_OFS = 1, STAT_OFS = 2.
  - TIMEOUT_RDATA = 32'hDEAD_BEEF.
- Sub-module io_ch_decode: a combinational priority encoder from the word address to {hit_ext, ch_idx, hit_local}.

## Test plan
- Local store 0x1F to LED offset with LOCAL_BIT set: leds = 5'h1F next cycle; cpu_stall stays 0 throughout.
- Load from channel 3, with ch_ack[3] asserted 4 cycles after ch_req[3] carrying 0x1234_5678: stall lasts 5 cycles, DONE returns 0x1234_5678, ch_req[3] falls on the ack edge.
- Address with channel bits 2 and 5 both set: only ch_req[5] is asserted; ack on channel 2 is ignored.
- With IO_TIMEOUT_EN and no ack: after 255 WAIT cycles, DONE returns 0xDEADBEEF, err = 1 and err_addr = access address. Writing 1 to status bit0 clears both.
- Reset asserted in the 2nd WAIT cycle: ch_req = 0 and state is IDLE next cycle, leds = 0; a subsequent access works normally.
- Non-IO load: cpu_rdata tracks mem_rdata and cpu_stall = 0.
